// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the ID/EX pipeline control and hazard_ctrl.
// The pipeline side (master) drives ID fields and branch resolution; the controller answers.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_reg_read_addr_1;
    logic [REG_ADDR_W-1:0] id_reg_read_addr_2;
    logic                  id_reg_write_enable;
    logic [REG_ADDR_W-1:0] id_reg_write_addr;
    logic                  id_reg_write_select;
    logic                  mem_branch_taken;
    logic                  stall_flag;
    logic                  branch_flag;
    logic [1:0]            fwd_sel_1;
    logic [1:0]            fwd_sel_2;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_valid, id_reg_read_addr_1, id_reg_read_addr_2,
               id_reg_write_enable, id_reg_write_addr, id_reg_write_select,
               mem_branch_taken,
        input  stall_flag, branch_flag, fwd_sel_1, fwd_sel_2,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_reg_read_addr_1, id_reg_read_addr_2,
               id_reg_write_enable, id_reg_write_addr, id_reg_write_select,
               mem_branch_taken,
        output stall_flag, branch_flag, fwd_sel_1, fwd_sel_2,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and EX forwarding control from a shadow scoreboard (EX/MEM/WB/WB2).
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    typedef logic [REG_ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        logic  we;
        logic  is_load;
        addr_t dst;
    } slot_t;

    slot_t r_ex, r_mem, r_wb, r_wb2;
    addr_t r_ex_src1, r_ex_src2;

    slot_t w_id_slot;
    logic  w_hazard, w_branch, w_stall, w_mem_load_hit;

    function automatic logic wr_match(slot_t s, addr_t r);
        return s.valid && s.we && (s.dst == r) && (r != '0);
    endfunction

    // A load still in MEM cannot be forwarded; the stall should have kept it from happening.
    function automatic logic [1:0] fwd_pick(slot_t ex, slot_t mem, slot_t wb, slot_t wb2, addr_t src);
        if (!ex.valid)           return 2'd0;
        if (wr_match(mem, src))  return mem.is_load ? 2'd0 : 2'd1;
        if (wr_match(wb, src))   return 2'd2;
        if (wr_match(wb2, src))  return 2'd3;
        return 2'd0;
    endfunction

    always_comb begin
        w_id_slot         = '0;
        w_id_slot.valid   = hz.id_valid;
        w_id_slot.we      = hz.id_reg_write_enable;
        w_id_slot.is_load = hz.id_reg_write_select;
        w_id_slot.dst     = hz.id_reg_write_addr;
    end

    assign w_hazard = hz.id_valid && r_ex.is_load &&
                      (wr_match(r_ex, hz.id_reg_read_addr_1) || wr_match(r_ex, hz.id_reg_read_addr_2));
    assign w_branch = hz.mem_branch_taken && r_mem.valid;
    assign w_stall  = w_hazard && !w_branch;

    assign hz.stall_flag  = w_stall;
    assign hz.branch_flag = w_branch;
    assign hz.fwd_sel_1   = fwd_pick(r_ex, r_mem, r_wb, r_wb2, r_ex_src1);
    assign hz.fwd_sel_2   = fwd_pick(r_ex, r_mem, r_wb, r_wb2, r_ex_src2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex      <= '0;
            r_mem     <= '0;
            r_wb      <= '0;
            r_wb2     <= '0;
            r_ex_src1 <= '0;
            r_ex_src2 <= '0;
        end else begin
            r_wb2 <= r_wb;
            r_wb  <= r_mem;
            if (w_branch) begin
                r_mem <= '0;
                r_ex  <= '0;
            end else if (w_stall) begin
                r_mem <= r_ex;
                r_ex  <= '0;
            end else begin
                r_mem     <= r_ex;
                r_ex      <= w_id_slot;
                r_ex_src1 <= hz.id_reg_read_addr_1;
                r_ex_src2 <= hz.id_reg_read_addr_2;
            end
        end
    end

    assign w_mem_load_hit = r_ex.valid && r_mem.is_load &&
                            (wr_match(r_mem, r_ex_src1) || wr_match(r_mem, r_ex_src2));

    a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (rst) !w_mem_load_hit);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_branch && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_count = r_stall_cnt;
    assign hz.flush_count = r_flush_cnt;
`else
    assign hz.stall_count = '0;
    assign hz.flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl: per-cycle vectors checked through a scoreboard queue,
// plus hand-written reset-mid-stall and perf-counter sequences.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hif();
    hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) u_dut (.clk(clk), .rst(rst), .hz(hif.slave));

    typedef struct {
        logic          v;
        logic [AW-1:0] a1, a2;
        logic          we;
        logic [AW-1:0] wa;
        logic          ld, br;
        logic          st, bf;
        logic [1:0]    f1, f2;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   nchk = 0;
    int   nerr = 0;
    int   stall_m = 0;
    int   flush_m = 0;

    function automatic vec_t V(int v, int a1, int a2, int we, int wa, int ld, int br,
                               int st, int bf, int f1, int f2);
        vec_t t;
        t.v = v[0]; t.a1 = AW'(a1); t.a2 = AW'(a2); t.we = we[0]; t.wa = AW'(wa);
        t.ld = ld[0]; t.br = br[0]; t.st = st[0]; t.bf = bf[0]; t.f1 = f1[1:0]; t.f2 = f2[1:0];
        return t;
    endfunction

    function automatic vec_t BUB();
        return V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input vec_t t, input string tag);
        vec_t e;
        @(negedge clk);
        hif.id_valid            = t.v;
        hif.id_reg_read_addr_1  = t.a1;
        hif.id_reg_read_addr_2  = t.a2;
        hif.id_reg_write_enable = t.we;
        hif.id_reg_write_addr   = t.wa;
        hif.id_reg_write_select = t.ld;
        hif.mem_branch_taken    = t.br;
        sb.push_back(t);
        #1;
        e = sb.pop_front();
        chk({tag, " stall"},  16'(hif.stall_flag),  16'(e.st));
        chk({tag, " branch"}, 16'(hif.branch_flag), 16'(e.bf));
        chk({tag, " fwd1"},   16'(hif.fwd_sel_1),   16'(e.f1));
        chk({tag, " fwd2"},   16'(hif.fwd_sel_2),   16'(e.f2));
        if (e.st && stall_m < (1 << CW) - 1) stall_m++;
        if (e.bf && flush_m < (1 << CW) - 1) flush_m++;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, " stall_count"}, 16'(hif.stall_count), 16'(stall_m));
        chk({tag, " flush_count"}, 16'(hif.flush_count), 16'(flush_m));
`else
        chk({tag, " stall_count"}, 16'(hif.stall_count), 16'd0);
        chk({tag, " flush_count"}, 16'(hif.flush_count), 16'd0);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) tbl.push_back(BUB());
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"},  16'(hif.stall_flag),  16'd0);
        chk({tag, " branch"}, 16'(hif.branch_flag), 16'd0);
        chk({tag, " fwd1"},   16'(hif.fwd_sel_1),   16'd0);
        chk({tag, " fwd2"},   16'(hif.fwd_sel_2),   16'd0);
        chk({tag, " stall_count"}, 16'(hif.stall_count), 16'd0);
        chk({tag, " flush_count"}, 16'(hif.flush_count), 16'd0);
    endtask

    // lw x3 ; add x4,x3,x1 pattern, one load-use stall each time
    task automatic load_use_pair(input string tag);
        step(V(1, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0), {tag, " lw"});
        step(V(1, 3, 1, 1, 4, 0, 0, 1, 0, 0, 0), {tag, " use-stall"});
        step(V(1, 3, 1, 1, 4, 0, 0, 0, 0, 0, 0), {tag, " use-held"});
        step(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), {tag, " use-in-ex"});
    endtask

    initial begin
        hif.id_valid = 1'b0; hif.id_reg_read_addr_1 = '0; hif.id_reg_read_addr_2 = '0;
        hif.id_reg_write_enable = 1'b0; hif.id_reg_write_addr = '0;
        hif.id_reg_write_select = 1'b0; hif.mem_branch_taken = 1'b0;

        // A: load-use stall, then WB forward into the dependent add
        tbl.push_back(V(1, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 3, 1, 1, 4, 0, 0, 1, 0, 0, 0));
        tbl.push_back(V(1, 3, 1, 1, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        drain();
        // B: back-to-back ALU dependency forwards from EX/MEM
        tbl.push_back(V(1, 1, 2, 1, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 5, 5, 1, 6, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        drain();
        // C: one independent instruction between -> WB mux
        tbl.push_back(V(1, 1, 2, 1, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 8, 9, 1, 7, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 5, 5, 1, 6, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2));
        drain();
        // D: two independent instructions between -> WB register
        tbl.push_back(V(1, 1, 2, 1, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 8, 9, 1, 7, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 10, 11, 1, 12, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 5, 5, 1, 6, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3));
        drain();
        // E: x0 never creates a hazard nor a forward
        tbl.push_back(V(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain();
        // F: branch in MEM with load-use in ID; branch wins, repeat pulse ignored
        tbl.push_back(V(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(V(1, 3, 1, 1, 4, 0, 1, 0, 1, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        drain();

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // reset pulsed in the middle of a stall cycle
        step(V(1, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0), "rst lw");
        step(V(1, 3, 1, 1, 4, 0, 0, 1, 0, 0, 0), "rst use-stall");
        #1 rst = 1'b1;
        #1 chk_all_zero("mid-stall reset");
        stall_m = 0;
        flush_m = 0;
        @(negedge clk);
        hif.id_valid = 1'b0;
        rst = 1'b0;
        load_use_pair("post-reset");

        for (int i = 0; i < 20; i++) load_use_pair($sformatf("pair%0d", i));
        for (int i = 0; i < 4; i++) step(BUB(), "drain");
        for (int i = 0; i < 3; i++) begin
            step(V(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("br%0d issue", i));
            step(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("br%0d ex", i));
            step(V(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), $sformatf("br%0d flush", i));
        end
        step(BUB(), "final");
        chk_cnt("perf");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. Keeps a shadow scoreboard of the destination registers of in-flight instructions (EX, MEM, WB, post-WB). From it, generates:
- `stall_flag` for load-use hazards.
- `branch_flag` flushes on taken branches resolved in MEM.
- Per-operand forwarding selects for the EX-stage ALU input muxes.

It is the single source of `stall_flag`/`branch_flag` for all pipeline register interfaces.

## Interface
- `REG_ADDR_W`, 5: register address width.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_valid` in 1: ID stage holds a valid instruction.
- `id_reg_read_addr_1`, `id_reg_read_addr_2` in `REG_ADDR_W`: ID source registers.
- `id_reg_write_enable` in 1: ID instruction writes the register file.
- `id_reg_write_addr` in `REG_ADDR_W`: ID destination register.
- `id_reg_write_select` in 1: 1 = ID instruction is a load (writeback from data memory).
- `mem_branch_taken` in 1: branch in MEM resolved taken this cycle.
- `stall_flag` out 1: hold IF/ID, insert bubble into EX.
- `branch_flag` out 1: flush IF, ID and EX registers.
- `fwd_sel_1`, `fwd_sel_2` out 2: EX operand source; 0 = register file, 1 = EX/MEM `alu_out`, 2 = MEM/WB writeback mux output, 3 = WB-register value.
- `stall_count`, `flush_count` out `CNT_W`: performance counters (see Configuration).

## Operation
- Scoreboard has four slots: EX, MEM, WB, WB2.
  - Each slot holds {valid, we, dst, is_load}.
  - The EX slot additionally holds {src1, src2}.
- A "writer match" on register r requires all of: valid, we, dst == r, r != 0. x0 never matches.
- Load-use hazard: `id_valid`, the EX slot is a load writer, and its dst matches `id_reg_read_addr_1` or `id_reg_read_addr_2`.
- `stall_flag` = hazard AND NOT `branch_flag` (combinational).
- `branch_flag` = `mem_branch_taken` AND MEM slot valid (combinational).
- Slot update per clock edge, highest priority first:
  - Branch: WB2←WB, WB←MEM, MEM←bubble, EX←bubble.
  - Stall: WB2←WB, WB←MEM, MEM←EX, EX←bubble.
  - Normal: full shift. EX←ID fields when `id_valid`, else bubble.
- Forwarding for operand n, evaluated on EX.src_n:
  - MEM non-load writer match → 1.
  - Else WB match → 2.
  - Else WB2 match → 3.
  - Else 0.
  - Invalid EX slot → 0.
- MEM load writer match on an EX source is prevented by the stall and is never forwarded. The RTL selects 0 in that case, and an assertion flags it.
- Simultaneous branch and load-use: branch wins, `stall_flag`=0, and the ID instruction is flushed.

## Timing
- `stall_flag`, `branch_flag` and `fwd_sel_*` are combinational from current state and ID inputs. They are valid in the same cycle so the pipeline registers act at the next edge.
- A load-use stall lasts exactly one cycle. The following cycle the load is in MEM with a bubble in EX, and the dependent instruction enters EX one cycle later with `fwd_sel`=2.
- A branch flush lasts one cycle per `mem_branch_taken` pulse. Because MEM is bubbled, a second consecutive `mem_branch_taken` does not re-assert `branch_flag`.
- Reset, asserted at any time including mid-stall or mid-flush:
  - All slots are invalid.
  - `stall_flag`=0, `branch_flag`=0, `fwd_sel_*`=0, counters=0.
  - Normal operation resumes on the first edge after deassertion.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_count` increments on each edge with `stall_flag`=1.
  - `flush_count` increments on each edge with `branch_flag`=1.
  - Both saturate at 2^`CNT_W`−1 and are cleared only by `rst`.
- Not defined: counters are not instantiated; `stall_count` and `flush_count` are tied to 0.

## Test plan
- Load x3, then `add x4,x3,x1` → `stall_flag`=1 for exactly one cycle; next EX cycle of the add has `fwd_sel_1`=2, `fwd_sel_2`=0.
- `add x5,x1,x2` then `sub x6,x5,x5` → no stall; `fwd_sel_1`=`fwd_sel_2`=1 in the sub's EX cycle. With one independent instruction between them, both selects are 2; with two between, both are 3.
- Load x0, then use x0 → `stall_flag`=0, `fwd_sel`=0.
- Load-use hazard present while `mem_branch_taken`=1 → `branch_flag`=1, `stall_flag`=0; the next cycle EX and MEM slots are empty and `fwd_sel`=0.
- `rst` pulsed during a stall cycle → all outputs 0 immediately; the same load/use pair after reset stalls one cycle again.
- With `HAZARD_PERF_CNT_EN` and `CNT_W`=4: 20 load-use pairs give `stall_count`=15 (saturated), and 3 taken branches give `flush_count`=3. Without the macro, both read 0.
